// File: rtl/hdca_pkg.sv
// Shared types for the HDCA instruction sequencer: opcodes, instruction fields, FSM states.
package hdca_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned DST_W  = 6;
  localparam int unsigned ARG_W  = 22;

  typedef enum logic [OP_W-1:0] {
    NOP     = 4'h0,
    BLD     = 4'h1,
    BSRT    = 4'h2,
    ILD     = 4'h3,
    ISRT    = 4'h4,
    XORLDA  = 4'h5,
    XORLDB  = 4'h6,
    XORSTR  = 4'h7,
    ROTLDB  = 4'h8,
    ROTLDS  = 4'h9,
    ROTSTR  = 4'hA,
    PSUMLDS = 4'hB,
    PSUMSTR = 4'hC,
    MAJLDL  = 4'hD,
    MAJLDS  = 4'hE,
    MAJSTR  = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_ISSUE,
    S_DLOAD,
    S_DRAIN,
    S_DONE
  } seq_state_e;

  typedef struct packed {
    opcode_e             op;
    logic [DST_W-1:0]    dst;
    logic [ARG_W-1:0]    arg;
  } instr_t;

  // Opcodes followed by a data packet on the stream.
  function automatic logic is_load(input opcode_e op);
    return (op == BLD) || (op == ILD);
  endfunction

endpackage

// File: rtl/hdca_inst_sequencer_if.sv
// Stream, issue and load-data handshakes between the sequencer and its neighbours.
interface hdca_inst_sequencer_if;
  import hdca_pkg::*;

  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              s_axis_tlast;

  logic              iss_valid;
  logic              iss_ready;
  opcode_e           iss_op;
  logic [DST_W-1:0]  iss_dst;
  logic [ARG_W-1:0]  iss_arg;

  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, iss_ready, ld_ready,
    output s_axis_tready, iss_valid, iss_op, iss_dst, iss_arg,
           ld_valid, ld_data, ld_last
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, iss_ready, ld_ready,
    input  s_axis_tready, iss_valid, iss_op, iss_dst, iss_arg,
           ld_valid, ld_data, ld_last
  );

endinterface

// File: rtl/hdca_inst_buf.sv
// Instruction buffer: one packet of words, synchronous write, asynchronous read, never cleared.
module hdca_inst_buf
  import hdca_pkg::*;
#(
  parameter  int unsigned DEPTH = 32,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              aclk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge aclk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/hdca_inst_sequencer.sv
// HDCA instruction fetch/issue controller: buffers one MM2S packet, issues it in order,
// and forwards the data packet following each BLD/ILD to the datapath load port.
module hdca_inst_sequencer
  import hdca_pkg::*;
#(
  parameter  int unsigned DEPTH = 32,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   ctrl_soft_rst,
  input  logic                   ctrl_start,
  hdca_inst_sequencer_if.master  bus,
  input  logic                   dp_busy,
  output logic                   seq_busy,
  output logic                   seq_done,
  output logic                   seq_err,
  output logic [AW-1:0]          seq_pc
);

  seq_state_e        state, state_d;
  logic              start_q;
  logic [AW-1:0]     count, last_idx, pc;
  instr_t            iss_q;
  instr_t            instr_c;
  logic [DATA_W-1:0] rdata_c;
  logic              clr_c, start_edge_c, beat_c, ld_beat_c, iss_hs_c, advance_c, idle_c;

  assign clr_c        = !aresetn || ctrl_soft_rst;
  assign start_edge_c = ctrl_start && !start_q;
  assign idle_c       = (state == S_IDLE) || (state == S_DONE);
  assign instr_c      = instr_t'(rdata_c);
  assign beat_c       = (state == S_FETCH) && bus.s_axis_tvalid;
  assign ld_beat_c    = (state == S_DLOAD) && bus.s_axis_tvalid && bus.ld_ready;
  assign iss_hs_c     = (state == S_ISSUE) && bus.iss_ready;

  hdca_inst_buf #(.DEPTH(DEPTH)) u_buf (
    .aclk    (aclk),
    .we      (beat_c),
    .waddr   (count),
    .wdata   (bus.s_axis_tdata),
    .raddr   (pc),
    .rdata_c (rdata_c)
  );

  // State register.
  always_ff @(posedge aclk) begin
    if (clr_c) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next-state logic; advance_c marks the end of one instruction (pc step or drain).
  always_comb begin
    state_d   = state;
    advance_c = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: if (start_edge_c) state_d = S_FETCH;
      S_FETCH: begin
        if (beat_c && (bus.s_axis_tlast || count == AW'(DEPTH - 1))) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (instr_c.op == NOP) advance_c = 1'b1;
        else                   state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        if (iss_hs_c) begin
          if (is_load(iss_q.op)) state_d   = S_DLOAD;
          else                   advance_c = 1'b1;
        end
      end
      S_DLOAD: if (ld_beat_c && bus.s_axis_tlast) advance_c = 1'b1;
      S_DRAIN: if (!dp_busy) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (advance_c) state_d = (pc == last_idx) ? S_DRAIN : S_EXEC;
  end

  // Outputs decoded from state; the load port is a straight pass-through of the stream.
  always_comb begin
    bus.s_axis_tready = 1'b0;
    bus.iss_valid     = 1'b0;
    bus.ld_valid      = 1'b0;
    bus.ld_data       = '0;
    bus.ld_last       = 1'b0;
    seq_busy          = 1'b0;
    seq_done          = 1'b0;
    unique case (state)
      S_FETCH: begin
        bus.s_axis_tready = 1'b1;
        seq_busy          = 1'b1;
      end
      S_EXEC, S_DRAIN: seq_busy = 1'b1;
      S_ISSUE: begin
        bus.iss_valid = 1'b1;
        seq_busy      = 1'b1;
      end
      S_DLOAD: begin
        bus.s_axis_tready = bus.ld_ready;
        bus.ld_valid      = bus.s_axis_tvalid;
        bus.ld_data       = bus.s_axis_tdata;
        bus.ld_last       = bus.s_axis_tlast;
        seq_busy          = 1'b1;
      end
      S_DONE:  seq_done = 1'b1;
      default: ;
    endcase
  end

  // Fetch counter, program counter, issue fields and sticky overflow flag.
  always_ff @(posedge aclk) begin
    if (clr_c) begin
      start_q  <= 1'b0;
      count    <= '0;
      last_idx <= '0;
      pc       <= '0;
      iss_q    <= '0;
      seq_err  <= 1'b0;
    end else begin
      start_q <= ctrl_start;
      if (idle_c && start_edge_c) begin
        count   <= '0;
        pc      <= '0;
        seq_err <= 1'b0;
      end
      if (beat_c) begin
        count    <= count + 1'b1;
        last_idx <= count;
        if (count == AW'(DEPTH - 1) && !bus.s_axis_tlast) seq_err <= 1'b1;
      end
      if (state == S_EXEC && instr_c.op != NOP) iss_q <= instr_c;
      if (advance_c && pc != last_idx) pc <= pc + 1'b1;
    end
  end

  assign bus.iss_op  = iss_q.op;
  assign bus.iss_dst = iss_q.dst;
  assign bus.iss_arg = iss_q.arg;
  assign seq_pc      = pc;

endmodule

// File: tb/tb_hdca_inst_sequencer.sv
// Directed scoreboard bench for hdca_inst_sequencer: issue order, load forwarding,
// backpressure, overflow, soft reset and start-edge behaviour.
module tb_hdca_inst_sequencer;
  import hdca_pkg::*;

  logic       aclk;
  logic       aresetn;
  logic       ctrl_soft_rst;
  logic       ctrl_start;
  logic       dp_busy;
  logic       seq_busy;
  logic       seq_done;
  logic       seq_err;
  logic [4:0] seq_pc;

  hdca_inst_sequencer_if bus ();

  hdca_inst_sequencer #(.DEPTH(32)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .ctrl_soft_rst (ctrl_soft_rst),
    .ctrl_start    (ctrl_start),
    .bus           (bus),
    .dp_busy       (dp_busy),
    .seq_busy      (seq_busy),
    .seq_done      (seq_done),
    .seq_err       (seq_err),
    .seq_pc        (seq_pc)
  );

  int vectors = 0;
  int miscompares = 0;
  int iss_hs = 0;
  int ld_hs = 0;
  logic [31:0] iss_sb[$];
  logic [32:0] ld_sb[$];
  logic [31:0] pkt[32];
  logic [3:0]  ops[13];
  logic        ok;
  logic        seen_ready;
  int          accepted;
  int          k;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // Present one beat and hold it until the DUT shows tready; returns whether it was taken.
  task automatic send_beat(input logic [31:0] d, input logic l, output logic taken);
    bus.s_axis_tdata  = d;
    bus.s_axis_tlast  = l;
    bus.s_axis_tvalid = 1'b1;
    taken = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge aclk);
      if (bus.s_axis_tready) begin
        taken = 1'b1;
        break;
      end
    end
    @(posedge aclk);
    #1;
    bus.s_axis_tvalid = 1'b0;
  endtask

  // Scoreboard: every issue/load handshake pops and compares the oldest expectation.
  always @(negedge aclk) begin
    if (aresetn && !ctrl_soft_rst && bus.iss_valid && bus.iss_ready) begin
      iss_hs++;
      check("iss_expected", 64'(iss_sb.size() != 0), 64'd1);
      if (iss_sb.size() != 0)
        check("iss_word", 64'({bus.iss_op, bus.iss_dst, bus.iss_arg}), 64'(iss_sb.pop_front()));
    end
    if (aresetn && !ctrl_soft_rst && bus.ld_valid && bus.ld_ready) begin
      ld_hs++;
      check("ld_expected", 64'(ld_sb.size() != 0), 64'd1);
      if (ld_sb.size() != 0)
        check("ld_word", 64'({bus.ld_last, bus.ld_data}), 64'(ld_sb.pop_front()));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ops = '{4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h2, 4'h4};
    aresetn = 1'b0; ctrl_soft_rst = 1'b0; ctrl_start = 1'b0; dp_busy = 1'b0;
    bus.s_axis_tdata = '0; bus.s_axis_tvalid = 1'b0; bus.s_axis_tlast = 1'b0;
    bus.iss_ready = 1'b0; bus.ld_ready = 1'b1;

    // Reset state
    step(3);
    check("rst_busy",  64'(seq_busy), 64'd0);
    check("rst_done",  64'(seq_done), 64'd0);
    check("rst_err",   64'(seq_err), 64'd0);
    check("rst_tready", 64'(bus.s_axis_tready), 64'd0);
    check("rst_iss_valid", 64'(bus.iss_valid), 64'd0);
    check("rst_ld_valid", 64'(bus.ld_valid), 64'd0);
    check("rst_pc", 64'(seq_pc), 64'd0);
    aresetn = 1'b1;
    step(1);

    // Run 1: 20 instructions + 12 NOPs, BLD first with a 32-word load packet
    k = 0;
    for (int i = 0; i < 32; i++) begin
      if (i % 8 == 2 || i % 8 == 5 || i % 8 == 7) pkt[i] = 32'h0;
      else if (i == 0) pkt[i] = {4'h1, 6'd0, 22'd0};
      else begin
        k++;
        pkt[i] = {ops[(k - 1) % 13], 6'(k), 22'(k * 1234 + i)};
      end
    end
    bus.iss_ready = 1'b1;
    dp_busy = 1'b1;
    ctrl_start = 1'b1;
    check("start_tready_same_cycle", 64'(bus.s_axis_tready), 64'd0);
    step(1);
    ctrl_start = 1'b0;
    check("start_tready_next_cycle", 64'(bus.s_axis_tready), 64'd1);
    check("start_busy", 64'(seq_busy), 64'd1);
    for (int i = 0; i < 32; i++) begin
      if (pkt[i] != 32'h0) iss_sb.push_back(pkt[i]);
      send_beat(pkt[i], i == 31, ok);
      check("run1_fetch_beat", 64'(ok), 64'd1);
    end
    for (int j = 0; j < 32; j++) begin
      ld_sb.push_back({j == 31, 32'h0000B000 + 32'(j)});
      send_beat(32'h0000B000 + 32'(j), j == 31, ok);
      check("run1_load_beat", 64'(ok), 64'd1);
    end
    for (int c = 0; c < 1000 && iss_hs < 20; c++) step(1);
    step(5);
    check("run1_issue_count", 64'(iss_hs), 64'd20);
    check("run1_load_count", 64'(ld_hs), 64'd32);
    check("run1_sb_empty", 64'(iss_sb.size()), 64'd0);
    check("run1_done_while_dp_busy", 64'(seq_done), 64'd0);
    check("run1_busy_while_dp_busy", 64'(seq_busy), 64'd1);
    dp_busy = 1'b0;
    for (int c = 0; c < 20 && !seq_done; c++) step(1);
    check("run1_done", 64'(seq_done), 64'd1);
    check("run1_busy_after_done", 64'(seq_busy), 64'd0);
    check("run1_pc_last", 64'(seq_pc), 64'd31);
    check("run1_err", 64'(seq_err), 64'd0);

    // Run 2: single-beat XORSTR under backpressure; start held high afterwards
    bus.iss_ready = 1'b0;
    ctrl_start = 1'b1;
    step(1);
    check("run2_done_cleared", 64'(seq_done), 64'd0);
    check("run2_tready", 64'(bus.s_axis_tready), 64'd1);
    check("run2_pc_cleared", 64'(seq_pc), 64'd0);
    iss_sb.push_back({4'h7, 6'd1, 22'd0});
    send_beat({4'h7, 6'd1, 22'd0}, 1'b1, ok);
    check("run2_fetch_beat", 64'(ok), 64'd1);
    for (int c = 0; c < 20 && !bus.iss_valid; c++) step(1);
    for (int c = 0; c < 5; c++) begin
      check("run2_hold_valid", 64'(bus.iss_valid), 64'd1);
      check("run2_hold_word", 64'({bus.iss_op, bus.iss_dst, bus.iss_arg}), 64'({4'h7, 6'd1, 22'd0}));
      step(1);
    end
    check("run2_no_early_hs", 64'(iss_hs), 64'd20);
    bus.iss_ready = 1'b1;
    step(1);
    check("run2_one_hs", 64'(iss_hs), 64'd21);
    check("run2_valid_dropped", 64'(bus.iss_valid), 64'd0);
    step(3);
    check("run2_done", 64'(seq_done), 64'd1);
    step(5);
    check("run2_no_restart_done", 64'(seq_done), 64'd1);
    check("run2_no_restart_tready", 64'(bus.s_axis_tready), 64'd0);
    check("run2_no_restart_busy", 64'(seq_busy), 64'd0);
    ctrl_start = 1'b0;
    step(2);
    ctrl_start = 1'b1;
    step(1);
    ctrl_start = 1'b0;
    check("restart_tready", 64'(bus.s_axis_tready), 64'd1);
    check("restart_done_cleared", 64'(seq_done), 64'd0);

    // Run 3: 33 NOP beats without tlast -> 32 taken, overflow flagged
    accepted = 0;
    for (int i = 0; i < 32; i++) begin
      send_beat(32'h0, 1'b0, ok);
      if (ok) accepted++;
    end
    check("run3_accepted", 64'(accepted), 64'd32);
    bus.s_axis_tdata = 32'h0; bus.s_axis_tlast = 1'b0; bus.s_axis_tvalid = 1'b1;
    @(negedge aclk);
    check("run3_beat33_tready", 64'(bus.s_axis_tready), 64'd0);
    check("run3_err", 64'(seq_err), 64'd1);
    seen_ready = 1'b0;
    for (int c = 0; c < 100 && !seq_done; c++) begin
      step(1);
      seen_ready = seen_ready | bus.s_axis_tready;
    end
    check("run3_tready_stayed_low", 64'(seen_ready), 64'd0);
    check("run3_done", 64'(seq_done), 64'd1);
    check("run3_err_sticky", 64'(seq_err), 64'd1);
    check("run3_no_issue", 64'(iss_hs), 64'd21);
    bus.s_axis_tvalid = 1'b0;

    // Run 4: soft reset during ISSUE, with overflow flag set
    bus.iss_ready = 1'b0;
    ctrl_start = 1'b1;
    step(1);
    ctrl_start = 1'b0;
    iss_sb.push_back({4'h5, 6'd3, 22'h155});
    send_beat({4'h5, 6'd3, 22'h155}, 1'b0, ok);
    for (int i = 1; i < 32; i++) send_beat(32'h0, 1'b0, ok);
    for (int c = 0; c < 20 && !bus.iss_valid; c++) step(1);
    check("run4_in_issue", 64'(bus.iss_valid), 64'd1);
    check("run4_err_before", 64'(seq_err), 64'd1);
    ctrl_soft_rst = 1'b1;
    step(1);
    check("srst_iss_valid", 64'(bus.iss_valid), 64'd0);
    check("srst_busy", 64'(seq_busy), 64'd0);
    check("srst_err", 64'(seq_err), 64'd0);
    check("srst_tready", 64'(bus.s_axis_tready), 64'd0);
    check("srst_pc", 64'(seq_pc), 64'd0);
    iss_sb.delete();
    ctrl_start = 1'b1;
    step(1);
    ctrl_start = 1'b0;
    step(1);
    ctrl_soft_rst = 1'b0;
    step(2);
    check("srst_start_lost_busy", 64'(seq_busy), 64'd0);
    check("srst_start_lost_tready", 64'(bus.s_axis_tready), 64'd0);

    // tvalid presented in IDLE is ignored
    bus.s_axis_tdata = {4'h7, 6'd2, 22'd9}; bus.s_axis_tlast = 1'b1; bus.s_axis_tvalid = 1'b1;
    step(3);
    check("idle_tvalid_tready", 64'(bus.s_axis_tready), 64'd0);
    check("idle_tvalid_busy", 64'(seq_busy), 64'd0);
    bus.s_axis_tvalid = 1'b0;
    step(2);
    check("final_issue_count", 64'(iss_hs), 64'd21);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
